// File: rtl/evt_board_reader_pkg.sv
// Shared event-sync definitions: framing tags, field positions, FSM states
// and a word classifier used by the board reader.
package evt_board_reader_pkg;

    // Field positions inside a 64-bit payload (metadata flag sits above it)
    localparam int TAG_HI  = 63;
    localparam int TAG_LO  = 56;
    localparam int BID_HI  = 55;
    localparam int BID_LO  = 48;
    localparam int L0ID_HI = 31;
    localparam int L0ID_LO = 0;

    localparam logic [7:0] HDR_TAG = 8'hAB;
    localparam logic [7:0] FTR_TAG = 8'hCD;

    // err_flags bit order: [0] size, [1] board id, [2] no header, [3] no footer
    localparam int ERR_NO_HDR = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } evt_state_e;

    typedef enum logic [1:0] {
        W_DATA,
        W_HDR,
        W_FTR,
        W_META
    } word_kind_e;

    function automatic word_kind_e classify(input logic meta, input logic [7:0] tag);
        if (!meta)          return W_DATA;
        if (tag == HDR_TAG) return W_HDR;
        if (tag == FTR_TAG) return W_FTR;
        return W_META;
    endfunction

endpackage

// File: rtl/evt_board_reader_if.sv
// FIFO read side, downstream stream and event summary of the board reader.
interface evt_board_reader_if #(
    parameter int DATA_WIDTH     = 65,
    parameter int MAX_WORDS_BITS = 16
);
    logic [DATA_WIDTH-1:0]     fifo_data;
    logic                      fifo_empty;
    logic                      fifo_rd_en;
    logic [DATA_WIDTH-1:0]     out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      evt_done;
    logic [31:0]               evt_l0id;
    logic [MAX_WORDS_BITS-1:0] evt_nwords;
    logic [3:0]                err_flags;
    logic [31:0]               evt_count;

    // master: the reader block; slave: FIFO + downstream consumer
    modport master (
        input  fifo_data, fifo_empty, out_ready,
        output fifo_rd_en, out_data, out_valid,
               evt_done, evt_l0id, evt_nwords, err_flags, evt_count
    );
    modport slave (
        output fifo_data, fifo_empty, out_ready,
        input  fifo_rd_en, out_data, out_valid,
               evt_done, evt_l0id, evt_nwords, err_flags, evt_count
    );
endinterface

// File: rtl/evt_skid_buffer.sv
// Two-entry skid buffer between the FIFO read port and the output stream.
module evt_skid_buffer #(
    parameter int DATA_WIDTH = 65
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  srst_n_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [1:0]            count_o
);
    logic [1:0][DATA_WIDTH-1:0] mem_q;
    logic                       wr_ptr_q;
    logic                       rd_ptr_q;
    logic [1:0]                 count_q;

    // storage and pointers; caller guarantees no push when full, no pop when empty
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (!srst_n_i) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;
endmodule

// File: rtl/evt_board_reader.sv
// Reads one output board's event FIFO, forwards every word downstream and
// checks header/data/footer framing, publishing a summary per event.
module evt_board_reader
    import evt_board_reader_pkg::*;
#(
    parameter int DATA_WIDTH     = 65,
    parameter int BOARD_ID       = 0,
    parameter int MAX_WORDS_BITS = 16
) (
    input  logic               es_clk,
    input  logic               es_rst_n,
    input  logic               es_srst_n,
    evt_board_reader_if.master bus
);
    localparam int MW = MAX_WORDS_BITS;

    typedef struct packed {
        evt_state_e      state;
        logic [31:0]     cur_l0id;
        logic [3:0]      err;
        logic [MW-1:0]   wcnt;
        logic            done;
        logic [31:0]     l0id;
        logic [MW-1:0]   nwords;
        logic [3:0]      flags;
    } fsm_t;

    fsm_t                  r_q;
    logic [31:0]           evt_count_q;
    logic                  run_q;
    logic                  rd_inflight_q;
    logic                  rd_en;
    logic                  pop;
    logic                  head_vld;
    logic [DATA_WIDTH-1:0] head;
    logic [1:0]            skid_cnt;
    logic [2:0]            committed;
    word_kind_e            kind;
    logic                  bid_bad;
    logic [31:0]           hdr_l0id;
    logic [MW-1:0]         ftr_cnt;

    // Occupancy the skid will have after this edge without a new read:
    // counting the in-flight word and a same-cycle pop keeps 1 word/cycle.
    assign pop       = head_vld & bus.out_ready;
    assign committed = {1'b0, skid_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
    assign rd_en     = run_q & ~bus.fifo_empty & (skid_cnt != 2'd2) & (committed < 3'd2);

    // run_q holds reads off while in reset; in-flight tracks the 1-cycle FIFO latency
    always_ff @(posedge es_clk or negedge es_rst_n) begin
        if (!es_rst_n) begin
            run_q         <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else if (!es_srst_n) begin
            run_q         <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            rd_inflight_q <= rd_en;
        end
    end

    evt_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk_i    (es_clk),
        .rst_n_i  (es_rst_n),
        .srst_n_i (es_srst_n),
        .push_i   (rd_inflight_q),
        .data_i   (bus.fifo_data),
        .pop_i    (pop),
        .data_o   (head),
        .valid_o  (head_vld),
        .count_o  (skid_cnt)
    );

    assign kind     = classify(head[DATA_WIDTH-1], head[TAG_HI:TAG_LO]);
    assign bid_bad  = (head[BID_HI:BID_LO] != BOARD_ID[7:0]);
    assign hdr_l0id = head[L0ID_HI:L0ID_LO];
    assign ftr_cnt  = head[MW-1:0];

    // Framing FSM: words are classified as they leave the skid buffer
    always_ff @(posedge es_clk or negedge es_rst_n) begin
        if (!es_rst_n) begin
            r_q         <= '0;
            evt_count_q <= '0;
        end else if (!es_srst_n) begin
            r_q         <= '0;
            evt_count_q <= '0;
        end else begin
            r_q.done <= 1'b0;
            if (pop) begin
                unique case (r_q.state)
                    ST_IDLE: begin
                        if (kind == W_HDR) begin
                            r_q.state    <= ST_DATA;
                            r_q.cur_l0id <= hdr_l0id;
                            r_q.err      <= {2'b00, bid_bad, 1'b0};
                            r_q.wcnt     <= '0;
                        end else begin
                            r_q.err[ERR_NO_HDR] <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        case (kind)
                            W_DATA: if (!(&r_q.wcnt)) r_q.wcnt <= r_q.wcnt + MW'(1);
                            W_FTR: begin
                                r_q.done    <= 1'b1;
                                r_q.l0id    <= r_q.cur_l0id;
                                r_q.nwords  <= r_q.wcnt;
                                r_q.flags   <= {r_q.err[3:1], r_q.err[0] | (r_q.wcnt != ftr_cnt)};
                                evt_count_q <= evt_count_q + 32'd1;
                                r_q.state   <= ST_IDLE;
                            end
                            W_HDR: begin
                                // close the open event as footer-less, then start the new one
                                r_q.done     <= 1'b1;
                                r_q.l0id     <= r_q.cur_l0id;
                                r_q.nwords   <= r_q.wcnt;
                                r_q.flags    <= {1'b1, r_q.err[2:0]};
                                evt_count_q  <= evt_count_q + 32'd1;
                                r_q.cur_l0id <= hdr_l0id;
                                r_q.err      <= {2'b00, bid_bad, 1'b0};
                                r_q.wcnt     <= '0;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = head;
    assign bus.out_valid  = head_vld;
    assign bus.evt_done   = r_q.done;
    assign bus.evt_l0id   = r_q.l0id;
    assign bus.evt_nwords = r_q.nwords;
    assign bus.err_flags  = r_q.flags;
    assign bus.evt_count  = evt_count_q;
endmodule

// File: tb/tb_evt_board_reader.sv
// Bench for evt_board_reader: FIFO source model, event-level reference model,
// stream/summary scoreboard and directed + randomized scenarios.
module tb_evt_board_reader;
    localparam int DW    = 65;
    localparam int MW    = 16;
    localparam int BOARD = 0;

    typedef struct packed {
        logic [31:0] l0id;
        logic [15:0] nw;
        logic [3:0]  err;
        logic [31:0] cnt;
    } rec_t;

    logic es_clk = 1'b0;
    logic es_rst_n;
    logic es_srst_n;

    evt_board_reader_if #(.DATA_WIDTH(DW), .MAX_WORDS_BITS(MW)) bus ();

    evt_board_reader #(.DATA_WIDTH(DW), .BOARD_ID(BOARD), .MAX_WORDS_BITS(MW)) dut (
        .es_clk    (es_clk),
        .es_rst_n  (es_rst_n),
        .es_srst_n (es_srst_n),
        .bus       (bus)
    );

    always #5 es_clk = ~es_clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- source FIFO: data valid the cycle after a read ----------
    logic [DW-1:0] src [0:1023];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic flush  = 1'b0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge es_clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (bus.fifo_rd_en && rd_ptr != wr_ptr) begin
            bus.fifo_data <= src[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // ---------------- downstream ready patterns -------------------------------
    int mode = 3;
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge es_clk); #1;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor --------------------------------------------------
    int   cyc = 0, issued = 0, xfer = 0, viol = 0;
    logic prev_rd = 1'b0;
    logic [DW-1:0] got_words[$], exp_words[$];
    rec_t got_rec[$], exp_rec[$];
    int   rd_cyc[$], xfer_cyc[$];

    always @(negedge es_clk) begin
        cyc <= cyc + 1;
        if (!es_rst_n || !es_srst_n) begin
            issued  <= 0;
            xfer    <= 0;
            prev_rd <= 1'b0;
            got_words.delete();
            got_rec.delete();
        end else begin
            prev_rd <= bus.fifo_rd_en;
            if (bus.fifo_rd_en) begin
                issued <= issued + 1;
                rd_cyc.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                xfer <= xfer + 1;
                got_words.push_back(bus.out_data);
                xfer_cyc.push_back(cyc);
            end
            // a read must never target an empty FIFO, a full skid, or overflow it
            if (bus.fifo_rd_en && (bus.fifo_empty || (issued - xfer - int'(prev_rd)) >= 2 ||
                (issued - xfer + 1 - int'(bus.out_valid && bus.out_ready)) > 2))
                viol <= viol + 1;
            if (bus.evt_done)
                got_rec.push_back(rec_t'({bus.evt_l0id, bus.evt_nwords, bus.err_flags, bus.evt_count}));
        end
    end

    // ---------------- checking -------------------------------------------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rd_en"},  128'(bus.fifo_rd_en), 128'(0));
        chk({tag, "_valid"},  128'(bus.out_valid),  128'(0));
        chk({tag, "_done"},   128'(bus.evt_done),   128'(0));
        chk({tag, "_data"},   128'(bus.out_data),   128'(0));
        chk({tag, "_l0id"},   128'(bus.evt_l0id),   128'(0));
        chk({tag, "_nwords"}, 128'(bus.evt_nwords), 128'(0));
        chk({tag, "_flags"},  128'(bus.err_flags),  128'(0));
        chk({tag, "_count"},  128'(bus.evt_count),  128'(0));
    endtask

    // ---------------- event-level reference model ------------------------------
    bit          pend = 1'b0;
    logic [31:0] pend_l0id;
    int          pend_n;
    logic [3:0]  pend_err;
    logic [31:0] exp_cnt = '0;

    function automatic logic [DW-1:0] mk_hdr(input logic [31:0] l0id, input logic [7:0] bid);
        return {1'b1, 8'hAB, bid, 16'h0000, l0id};
    endfunction

    function automatic logic [DW-1:0] mk_ftr(input int cnt);
        return {1'b1, 8'hCD, 40'h0, 16'(cnt)};
    endfunction

    function automatic logic [DW-1:0] mk_dat();
        return {1'b0, $urandom(), $urandom()};
    endfunction

    task automatic put(input logic [DW-1:0] w, input bit expect_out);
        src[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1;
        if (expect_out) exp_words.push_back(w);
    endtask

    // Every word comes back out unchanged; each footer or interrupting header
    // yields one summary built from the event's own description.
    task automatic send_event(input logic [31:0] l0id, input logic [7:0] bid,
                              input int ndata, input int fcnt, input bit with_ftr);
        logic [3:0] e;
        if (pend) begin
            exp_cnt = exp_cnt + 32'd1;
            exp_rec.push_back(rec_t'({pend_l0id, 16'(pend_n), pend_err | 4'b1000, exp_cnt}));
        end
        put(mk_hdr(l0id, bid), 1'b1);
        for (int i = 0; i < ndata; i++) put(mk_dat(), 1'b1);
        e = {2'b00, bid != BOARD[7:0], 1'b0};
        if (with_ftr) begin
            put(mk_ftr(fcnt), 1'b1);
            exp_cnt = exp_cnt + 32'd1;
            exp_rec.push_back(rec_t'({l0id, 16'(ndata), e | {3'b000, ndata != fcnt}, exp_cnt}));
            pend = 1'b0;
        end else begin
            pend      = 1'b1;
            pend_l0id = l0id;
            pend_n    = ndata;
            pend_err  = e;
        end
    endtask

    task automatic drain(input string tag);
        int   n = 0;
        logic timed;
        while ((rd_ptr != wr_ptr || got_words.size() < exp_words.size()) && n < 2000) begin
            @(negedge es_clk);
            n++;
        end
        repeat (4) @(negedge es_clk);
        timed = (n >= 2000);
        chk({tag, "_timeout"}, 128'(timed), 128'(0));
        chk({tag, "_nwords_out"}, 128'(got_words.size()), 128'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), 128'(got_words[i]), 128'(exp_words[i]));
        chk({tag, "_nevents"}, 128'(got_rec.size()), 128'(exp_rec.size()));
        for (int i = 0; i < exp_rec.size() && i < got_rec.size(); i++)
            chk($sformatf("%s_evt%0d", tag, i), 128'(got_rec[i]), 128'(exp_rec[i]));
        chk({tag, "_rd_violations"}, 128'(viol), 128'(0));
        got_words.delete();
        exp_words.delete();
        got_rec.delete();
        exp_rec.delete();
    endtask

    // ---------------- watchdog -------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", n_checks, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------------------------------
    initial begin
        es_rst_n  = 1'b0;
        es_srst_n = 1'b1;
        repeat (3) @(posedge es_clk);
        @(negedge es_clk);
        check_reset("por");
        @(posedge es_clk); #1;
        es_rst_n = 1'b1;
        repeat (2) @(posedge es_clk); #1;

        // nominal event, full-rate downstream
        mode = 0;
        repeat (2) @(posedge es_clk); #1;
        rd_cyc.delete();
        xfer_cyc.delete();
        send_event(32'h12, 8'd0, 5, 5, 1'b1);
        drain("nominal");
        chk("nominal_xfers", 128'(xfer_cyc.size()), 128'(7));
        chk("nominal_back2back", 128'(xfer_cyc[6] - xfer_cyc[0]), 128'(6));
        chk("nominal_latency", 128'(xfer_cyc[0] - rd_cyc[0]), 128'(2));
        chk("nominal_count_out", 128'(bus.evt_count), 128'(1));

        // same event through a toggling downstream
        mode = 1;
        send_event(32'h12, 8'd0, 5, 5, 1'b1);
        drain("toggle");

        // footer count disagrees with data words seen
        mode = 0;
        send_event(32'h34, 8'd0, 5, 4, 1'b1);
        drain("size_err");

        // wrong board id, then a header interrupts the event
        mode = 2;
        send_event(32'h56, 8'd3, 2, 2, 1'b0);
        send_event(32'h78, 8'd0, 3, 3, 1'b1);
        drain("bid_and_nofooter");

        // randomized mix of sizes, ids, footer counts and missing footers
        for (int i = 0; i < 8; i++) begin
            logic [7:0] bid;
            int nd, fc;
            bit wf;
            nd  = $urandom_range(0, 7);
            fc  = ($urandom_range(0, 3) == 0) ? nd + 1 : nd;
            bid = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            wf  = (i == 7) ? 1'b1 : ($urandom_range(0, 3) != 0);
            send_event($urandom(), bid, nd, fc, wf);
        end
        drain("random");

        // soft reset while idle clears the summary
        @(posedge es_clk); #1;
        es_srst_n = 1'b0;
        @(posedge es_clk); #1;
        es_srst_n = 1'b1;
        @(negedge es_clk);
        chk("srst_count", 128'(bus.evt_count), 128'(0));
        chk("srst_l0id", 128'(bus.evt_l0id), 128'(0));
        exp_cnt = '0;

        // async reset in the middle of an event with reads outstanding
        @(posedge es_clk); #1;
        mode = 3;
        put(mk_hdr(32'h9A, 8'd0), 1'b0);
        for (int i = 0; i < 5; i++) put(mk_dat(), 1'b0);
        repeat (4) @(posedge es_clk); #1;
        es_rst_n = 1'b0;
        @(negedge es_clk);
        chk("rst_mid_fifo_nonempty", 128'(bus.fifo_empty), 128'(0));
        check_reset("rst_mid");
        @(posedge es_clk); #1;
        flush = 1'b1;
        @(posedge es_clk); #1;
        flush    = 1'b0;
        es_rst_n = 1'b1;
        exp_words.delete();
        exp_rec.delete();
        pend    = 1'b0;
        exp_cnt = '0;
        @(negedge es_clk);
        check_reset("post_rst");
        @(posedge es_clk); #1;
        mode = 0;
        send_event(32'h21, 8'd0, 3, 3, 1'b1);
        drain("after_rst");

        // event counter wrap from a preloaded all-ones value
        @(posedge es_clk); #1;
        force dut.evt_count_q = 32'hFFFF_FFFF;
        @(posedge es_clk); #1;
        release dut.evt_count_q;
        @(negedge es_clk);
        chk("wrap_preload", 128'(bus.evt_count), 128'(32'hFFFF_FFFF));
        exp_cnt = 32'hFFFF_FFFF;
        @(posedge es_clk); #1;
        send_event(32'hABC, 8'd0, 2, 2, 1'b1);
        drain("wrap");
        chk("wrap_count_out", 128'(bus.evt_count), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
